// File: rtl/snake_pkg.sv
`timescale 1ns / 1ps
// Shared defaults, LFSR taps and FSM state encoding for the snake-game food logic.
package snake_pkg;

  localparam int CELL_SIZE_DEF = 20;
  localparam int COLS_DEF      = 38;
  localparam int ROWS_DEF      = 28;
  localparam int COORD_W_DEF   = 11;
  localparam int LFSR_W_DEF    = 16;
  localparam int MAX_TRIES_DEF = 15;

  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  // Feedback taps q[15], q[13], q[12], q[10]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    DRAW_X,
    DRAW_Y,
    QUERY,
    SCAN_Q,
    DONE
  } fpg_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
`timescale 1ns / 1ps
// Free-running 16-bit Fibonacci LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] q_o
);

  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= SEED_NZ;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/food_point_gen.sv
`timescale 1ns / 1ps
// Food point generator: random free grid cell via LFSR draws and an occupancy handshake,
// falling back to a linear scan of the grid after repeated collisions.
module food_point_gen
  import snake_pkg::*;
#(
  parameter int                CELL_SIZE = CELL_SIZE_DEF,
  parameter int                COLS      = COLS_DEF,
  parameter int                ROWS      = ROWS_DEF,
  parameter int                COORD_W   = COORD_W_DEF,
  parameter int                LFSR_W    = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_SEED_DEF,
  parameter int                MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic               CLK_100MHz,
  input  logic               RST,
  input  logic               req,
  output logic               busy,
  output logic               valid,
  output logic [COORD_W-1:0] randX,
  output logic [COORD_W-1:0] randY,
  output logic               full,
  output logic               occ_req,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_ack,
  input  logic               occ_hit
);

  localparam int XW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int NCELLS = COLS * ROWS;
  localparam int SW     = $clog2(NCELLS + 1);
  localparam int TW     = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

  function automatic logic [COORD_W-1:0] to_pix(input logic [31:0] idx);
    logic [31:0] p;
    p = (idx + 32'd1) * 32'(CELL_SIZE);
    return p[COORD_W-1:0];
  endfunction

  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk_i(CLK_100MHz),
    .rst_i(RST),
    .q_o  (lfsr)
  );

  // Only the low index bits are drawn from; the reduction keeps the rest referenced.
  assign lfsr_unused = ^lfsr;

  logic [XW-1:0] cx_d;
  logic [YW-1:0] cy_d;
  logic          cx_ok_d;
  logic          cy_ok_d;

  assign cx_d    = lfsr[XW-1:0];
  assign cy_d    = lfsr[YW-1:0];
  assign cx_ok_d = 32'(cx_d) < 32'(COLS);
  assign cy_ok_d = 32'(cy_d) < 32'(ROWS);

  fpg_state_e         state_q;
  logic [XW-1:0]      cx_q;
  logic [YW-1:0]      cy_q;
  logic [TW-1:0]      tries_q;
  logic [SW-1:0]      scanned_q;
  logic               busy_q;
  logic               valid_q;
  logic               full_q;
  logic               occ_req_q;
  logic [COORD_W-1:0] occ_x_q;
  logic [COORD_W-1:0] occ_y_q;
  logic [COORD_W-1:0] randx_q;
  logic [COORD_W-1:0] randy_q;

  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      state_q   <= IDLE;
      tries_q   <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      occ_req_q <= 1'b0;
      occ_x_q   <= COORD_W'(CELL_SIZE);
      occ_y_q   <= COORD_W'(CELL_SIZE);
      randx_q   <= COORD_W'(CELL_SIZE);
      randy_q   <= COORD_W'(CELL_SIZE);
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= DRAW_X;
            busy_q  <= 1'b1;
            tries_q <= '0;
            full_q  <= 1'b0;
          end
        end
        DRAW_X: begin
          if (cx_ok_d) begin
            cx_q    <= cx_d;
            state_q <= DRAW_Y;
          end
        end
        DRAW_Y: begin
          // Issue the query straight away so a clean draw completes in minimum time
          if (cy_ok_d) begin
            cy_q      <= cy_d;
            occ_req_q <= 1'b1;
            occ_x_q   <= to_pix(32'(cx_q));
            occ_y_q   <= to_pix(32'(cy_d));
            state_q   <= QUERY;
          end
        end
        QUERY: begin
          if (occ_ack) begin
            occ_req_q <= 1'b0;
            if (!occ_hit) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              randx_q <= occ_x_q;
              randy_q <= occ_y_q;
            end else if (32'(tries_q) < 32'(MAX_TRIES)) begin
              tries_q <= tries_q + TW'(1);
              state_q <= DRAW_X;
            end else begin
              scanned_q <= '0;
              state_q   <= SCAN_Q;
            end
          end
        end
        SCAN_Q: begin
          // occ_req idles low for one cycle after every ack before the next cell is posted
          if (!occ_req_q) begin
            occ_req_q <= 1'b1;
            occ_x_q   <= to_pix(32'(cx_q));
            occ_y_q   <= to_pix(32'(cy_q));
          end else if (occ_ack) begin
            occ_req_q <= 1'b0;
            if (!occ_hit) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              randx_q <= occ_x_q;
              randy_q <= occ_y_q;
            end else if (32'(scanned_q) == 32'(NCELLS - 1)) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              full_q  <= 1'b1;
              randx_q <= to_pix(32'd0);
              randy_q <= to_pix(32'd0);
            end else begin
              scanned_q <= scanned_q + SW'(1);
              if (32'(cx_q) == 32'(COLS - 1)) begin
                cx_q <= '0;
                if (32'(cy_q) == 32'(ROWS - 1)) begin
                  cy_q <= '0;
                end else begin
                  cy_q <= cy_q + YW'(1);
                end
              end else begin
                cx_q <= cx_q + XW'(1);
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign full    = full_q;
  assign randX   = randx_q;
  assign randY   = randy_q;
  assign occ_req = occ_req_q;
  assign occ_x   = occ_x_q;
  assign occ_y   = occ_y_q;

endmodule

// File: tb/tb_food_point_gen.sv
`timescale 1ns / 1ps
// Bench for food_point_gen: default grid with a free-space responder, plus a 4x3 grid
// with hit-heavy responders for the scan fallback.
module tb_food_point_gen;
  import snake_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        req_a = 1'b0, busy_a, valid_a, full_a, occ_req_a, occ_ack_a, occ_hit_a;
  logic [10:0] randx_a, randy_a, occ_x_a, occ_y_a;
  logic        ack_hold_a = 1'b0;

  logic        req_b = 1'b0, busy_b, valid_b, full_b, occ_req_b, occ_ack_b, occ_hit_b;
  logic [10:0] randx_b, randy_b, occ_x_b, occ_y_b;
  logic        b_mode = 1'b0;

  food_point_gen u_dut_a (
    .CLK_100MHz(clk), .RST(rst), .req(req_a), .busy(busy_a), .valid(valid_a),
    .randX(randx_a), .randY(randy_a), .full(full_a), .occ_req(occ_req_a),
    .occ_x(occ_x_a), .occ_y(occ_y_a), .occ_ack(occ_ack_a), .occ_hit(occ_hit_a)
  );

  food_point_gen #(.COLS(4), .ROWS(3), .MAX_TRIES(2)) u_dut_b (
    .CLK_100MHz(clk), .RST(rst), .req(req_b), .busy(busy_b), .valid(valid_b),
    .randX(randx_b), .randY(randy_b), .full(full_b), .occ_req(occ_req_b),
    .occ_x(occ_x_b), .occ_y(occ_y_b), .occ_ack(occ_ack_b), .occ_hit(occ_hit_b)
  );

  // Responders: A is an empty board answering in the same cycle; B is all-occupied
  // (mode 0) or occupied everywhere except cell (2,1) = pixel (60,40) (mode 1).
  assign occ_ack_a = occ_req_a && !ack_hold_a;
  assign occ_hit_a = 1'b0;
  assign occ_ack_b = occ_req_b;
  assign occ_hit_b = b_mode ? !(occ_x_b == 11'd60 && occ_y_b == 11'd40) : 1'b1;

  int qcnt_b = 0;
  always @(posedge clk) if (occ_req_b && occ_ack_b) qcnt_b <= qcnt_b + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] lfsr_m;
  always @(posedge clk) lfsr_m <= rst ? 16'hACE1 : ref_step(lfsr_m);

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        full;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  bit seen_x[38];
  bit seen_y[28];
  int oor = 0;

  // Draw model for the default grid: cur is the LFSR value before the accepting edge
  task automatic predict(input logic [15:0] cur, output exp_t e, output int rej);
    logic [15:0] v;
    int cx, cy;
    rej = 0;
    v = ref_step(cur);
    while (int'(v[5:0]) >= 38) begin v = ref_step(v); rej++; end
    cx = int'(v[5:0]);
    v = ref_step(v);
    while (int'(v[4:0]) >= 28) begin v = ref_step(v); rej++; end
    cy = int'(v[4:0]);
    e.x = 11'((cx + 1) * 20);
    e.y = 11'((cy + 1) * 20);
    e.full = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int ix, iy;
    if (valid_a === 1'b1) begin
      if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_randX", randx_a, e.x);
        chk("a_randY", randy_a, e.y);
        chk("a_full", full_a, e.full);
        ix = int'(randx_a) / 20 - 1;
        iy = int'(randy_a) / 20 - 1;
        if (randx_a % 20 != 0 || ix < 0 || ix > 37 || randy_a % 20 != 0 || iy < 0 || iy > 27)
          oor++;
        else begin
          seen_x[ix] = 1'b1;
          seen_y[iy] = 1'b1;
        end
      end
    end
    if (valid_b === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_randX", randx_b, e.x);
        chk("b_randY", randy_b, e.y);
        chk("b_full", full_b, e.full);
      end
    end
  end

  // Called at a negedge with A idle; returns at a negedge with A back in IDLE
  task automatic req_a_txn(input bit check_busy);
    exp_t e;
    int rej, lat;
    bit got;
    predict(lfsr_m, e, rej);
    q_a.push_back(e);
    req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    if (check_busy) begin
      chk("a_busy_after_accept", busy_a, 1);
      chk("a_occ_req_in_draw", occ_req_a, 0);
    end
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid_a) begin got = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    chk("a_valid_seen", got, 1);
    if (got) begin
      chk("a_latency", lat, 4 + rej);
      if (check_busy) chk("a_busy_in_done", busy_a, 0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req_b_txn(input exp_t e, input int exp_q);
    int q0;
    bit got;
    q_b.push_back(e);
    q0 = qcnt_b;
    req_b = 1'b1;
    @(posedge clk);
    #1 req_b = 1'b0;
    chk("b_full_cleared_on_req", full_b, 0);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid_b) begin got = 1'b1; break; end
    end
    chk("b_valid_seen", got, 1);
    if (exp_q >= 0) chk("b_query_count", qcnt_b - q0, exp_q);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int nx, ny;
    bit found;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("lfsr_first_step", u_dut_a.u_lfsr.lfsr_q, 16'h59C3);
    repeat (9) @(negedge clk);
    chk("lfsr_model_idle", u_dut_a.u_lfsr.lfsr_q, lfsr_m);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_randX", randx_a, 20);
    chk("rst_randY", randy_a, 20);
    chk("rst_occ_req", occ_req_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_occ_x", occ_x_a, 20);
    chk("rst_b_randX", randx_b, 20);

    // Free board, same-cycle ack
    for (int i = 0; i < 20; i++) req_a_txn(1'b1);

    // Bulk draws for range and cell coverage
    for (int i = 0; i < 10000; i++) req_a_txn(1'b0);
    nx = 0;
    ny = 0;
    foreach (seen_x[i]) if (seen_x[i]) nx++;
    foreach (seen_y[i]) if (seen_y[i]) ny++;
    chk("x_cells_covered", nx, 38);
    chk("y_cells_covered", ny, 28);
    chk("out_of_range_points", oor, 0);

    // 4x3 grid, all occupied: 3 random queries + 12 scan queries, then full at (0,0)
    b_mode = 1'b0;
    e.x = 11'd20; e.y = 11'd20; e.full = 1'b1;
    req_b_txn(e, 15);
    chk("b_full_held", full_b, 1);
    chk("b_busy_idle", busy_b, 0);

    // 4x3 grid, only (2,1) free
    b_mode = 1'b1;
    e.x = 11'd60; e.y = 11'd40; e.full = 1'b0;
    req_b_txn(e, -1);
    req_b_txn(e, -1);

    // Reset during an outstanding query
    ack_hold_a = 1'b1;
    predict(lfsr_m, e, nx);
    q_a.push_back(e);
    req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (occ_req_a) begin found = 1'b1; break; end
    end
    chk("abort_occ_req_seen", found, 1);
    repeat (3) @(negedge clk);
    chk("abort_occ_req_held", occ_req_a, 1);
    chk("abort_occ_x_stable", occ_x_a, e.x);
    chk("abort_occ_y_stable", occ_y_a, e.y);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_occ_req_dropped", occ_req_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_state_idle", 32'(u_dut_a.state_q), 32'(IDLE));
    e = q_a.pop_back();
    @(negedge clk);
    rst = 1'b0;
    ack_hold_a = 1'b0;
    req_a_txn(1'b1);

    repeat (5) @(negedge clk);
    chk("a_scoreboard_drained", q_a.size(), 0);
    chk("b_scoreboard_drained", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
